// File: rtl/pcont_ifetch_q_pkg.sv
// Shared constants for the instruction fetch queue and the instruction register:
// ISA mode encodings, the M32 no-op and the one-hot instruction select positions.
package pcont_ifetch_q_pkg;

   localparam logic        M32     = 1'b0;
   localparam logic        M16     = 1'b1;
   localparam logic [31:0] M32_NOP = 32'h0000_0000;

   localparam int CLMI_SEL_INST_ZERO_POS = 0;
   localparam int CLMI_SEL_INST_LOAD_POS = 1;
   localparam int CLMI_SEL_INST_HOLD_POS = 2;
   localparam int CLMI_SEL_INST_HI       = 2;

   typedef enum logic [1:0] {
      SEL_ZERO = 2'd0,
      SEL_LOAD = 2'd1,
      SEL_HOLD = 2'd2
   } sel_e;

   function automatic logic [CLMI_SEL_INST_HI:0] sel_onehot(input sel_e s);
      logic [CLMI_SEL_INST_HI:0] v;
      v = '0;
      case (s)
         SEL_LOAD: v[CLMI_SEL_INST_LOAD_POS] = 1'b1;
         SEL_HOLD: v[CLMI_SEL_INST_HOLD_POS] = 1'b1;
         default:  v[CLMI_SEL_INST_ZERO_POS] = 1'b1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pcont_ifetch_q_fifo.sv
// DEPTH x 32 word FIFO for fetched instructions; synchronous flush beats push/pop.
module pcont_ifq_fifo #(
   parameter int DEPTH = 2
) (
   input  logic        SYSCLK,
   input  logic        RESET_D2_R_N,
   input  logic        flush,
   input  logic        push,
   input  logic [31:0] wdata,
   input  logic        pop,
   output logic [31:0] rdata,
   output logic        full,
   output logic        empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push_ok;
   logic          pop_ok;

   always_comb begin
      full    = (cnt == CW'(DEPTH));
      empty   = (cnt == '0);
      push_ok = push && !full && !flush;
      pop_ok  = pop && !empty && !flush;
      rdata   = mem[rd_ptr];
   end

   always_ff @(posedge SYSCLK) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
      if (!RESET_D2_R_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/pcont_ifetch_q.sv
// Instruction fetch queue: one-outstanding REQ/ACK fetcher, word FIFO, M16 halfword
// stepping and the ZERO/LOAD/HOLD select presented to the S-stage instruction register.
module pcont_ifetch_q
   import pcont_ifetch_q_pkg::*;
#(
   parameter int          DEPTH      = 2,
   parameter logic [31:1] RESET_ADDR = 31'h5FC0_0000,
   parameter logic        RESET_MODE = 1'b0
) (
   input  logic                        SYSCLK,
   input  logic                        RESET_D2_R_N,
   output logic                        IMEM_REQ,
   output logic [31:2]                 IMEM_ADDR,
   input  logic                        IMEM_ACK,
   input  logic [31:0]                 IMEM_RDATA,
   input  logic                        REDIRECT,
   input  logic [31:1]                 REDIRECT_ADDR,
   input  logic                        REDIRECT_MODE,
   input  logic                        CLMI_RHOLD,
   output logic [31:0]                 INST_I,
   output logic                        CP0_M16IADDRB1_I,
   output logic                        CP0_INSTM32_I_R_C1_N,
   output logic [CLMI_SEL_INST_HI:0]   CLMI_SELINST_S_P,
   output logic [31:1]                 IF_PC
);

   logic        live_q;
   logic        out_q;
   logic        dis_q;
   logic        mode_q;
   logic [31:1] ha_q;
   logic [31:2] fa_q;
   logic [31:2] oaddr_q;

   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_rdata;

   sel_e        sel;
   logic        load;
   logic        pop;
   logic        issue;
   logic        ack_ok;
   logic        push;
   logic [31:1] redir_ha;

   // live_q keeps the fetcher and the HOLD select quiet until the first edge after reset.
   always_comb begin
      sel = SEL_ZERO;
      if (!live_q || REDIRECT) sel = SEL_ZERO;
      else if (CLMI_RHOLD)     sel = SEL_HOLD;
      else if (!fifo_empty)    sel = SEL_LOAD;

      load      = (sel == SEL_LOAD);
      pop       = load && ((mode_q == M32) || ha_q[1]);
      issue     = live_q && !out_q && !fifo_full && !REDIRECT;
      IMEM_REQ  = out_q || issue;
      IMEM_ADDR = out_q ? oaddr_q : fa_q;
      ack_ok    = IMEM_ACK && IMEM_REQ;
      push      = ack_ok && !dis_q && !REDIRECT;
      redir_ha  = {REDIRECT_ADDR[31:2], REDIRECT_ADDR[1] & (REDIRECT_MODE == M16)};

      INST_I               = fifo_empty ? M32_NOP : fifo_rdata;
      CP0_M16IADDRB1_I     = ha_q[1];
      CP0_INSTM32_I_R_C1_N = mode_q;
      CLMI_SELINST_S_P     = sel_onehot(sel);
      IF_PC                = ha_q;
   end

   always_ff @(posedge SYSCLK or negedge RESET_D2_R_N) begin
      if (!RESET_D2_R_N) begin
         live_q  <= 1'b0;
         out_q   <= 1'b0;
         dis_q   <= 1'b0;
         mode_q  <= RESET_MODE;
         ha_q    <= RESET_ADDR;
         fa_q    <= RESET_ADDR[31:2];
         oaddr_q <= RESET_ADDR[31:2];
      end else begin
         live_q <= 1'b1;

         // The presented address is latched so it survives a redirect of fa_q.
         if (ack_ok) begin
            out_q <= 1'b0;
         end else if (issue) begin
            out_q   <= 1'b1;
            oaddr_q <= fa_q;
         end

         if (REDIRECT) begin
            ha_q   <= redir_ha;
            fa_q   <= REDIRECT_ADDR[31:2];
            mode_q <= REDIRECT_MODE;
            dis_q  <= out_q && !IMEM_ACK;
         end else begin
            if (ack_ok) begin
               if (dis_q) dis_q <= 1'b0;
               else       fa_q  <= IMEM_ADDR + 30'd1;
            end
            if (load) ha_q <= ha_q + ((mode_q == M32) ? 31'd2 : 31'd1);
         end
      end
   end

   pcont_ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .SYSCLK       (SYSCLK),
      .RESET_D2_R_N (RESET_D2_R_N),
      .flush        (REDIRECT),
      .push         (push),
      .wdata        (IMEM_RDATA),
      .pop          (pop),
      .rdata        (fifo_rdata),
      .full         (fifo_full),
      .empty        (fifo_empty)
   );

endmodule

// File: tb/tb_pcont_ifetch_q.sv
// Directed bench for pcont_ifetch_q: stimulus pushes expected presentations into a
// scoreboard queue, a negedge monitor pops and compares on every LOAD.
module tb_pcont_ifetch_q;
   import pcont_ifetch_q_pkg::*;

   // Halfword address of byte address 0x5FC0_0000, so the first word fetch is 0x17F0_0000.
   localparam logic [31:1] RST_HA = 31'h2FE0_0000;
   localparam logic [2:0]  S_ZERO = 3'b001;
   localparam logic [2:0]  S_LOAD = 3'b010;
   localparam logic [2:0]  S_HOLD = 3'b100;

   logic        sysclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:2] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:1] redirect_addr = '0;
   logic        redirect_mode = 1'b0;
   logic        rhold = 1'b0;
   logic [31:0] inst;
   logic        b1;
   logic        mode_n;
   logic [2:0]  sel;
   logic [31:1] if_pc;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] w;
      logic        b1;
      logic [31:1] pc;
   } exp_t;
   exp_t sbq[$];

   always #5 sysclk = ~sysclk;

   pcont_ifetch_q #(
      .DEPTH      (2),
      .RESET_ADDR (RST_HA),
      .RESET_MODE (1'b0)
   ) dut (
      .SYSCLK               (sysclk),
      .RESET_D2_R_N         (rst_n),
      .IMEM_REQ             (imem_req),
      .IMEM_ADDR            (imem_addr),
      .IMEM_ACK             (imem_ack),
      .IMEM_RDATA           (imem_rdata),
      .REDIRECT             (redirect),
      .REDIRECT_ADDR        (redirect_addr),
      .REDIRECT_MODE        (redirect_mode),
      .CLMI_RHOLD           (rhold),
      .INST_I               (inst),
      .CP0_M16IADDRB1_I     (b1),
      .CP0_INSTM32_I_R_C1_N (mode_n),
      .CLMI_SELINST_S_P     (sel),
      .IF_PC                (if_pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic at_neg();
      @(negedge sysclk);
   endtask

   task automatic next();
      @(posedge sysclk);
      #1;
   endtask

   task automatic expect_bus(input string tag, input logic req_e, input logic [31:2] a_e,
                             input logic [2:0] s_e);
      chk({tag, "_req"}, 64'(imem_req), 64'(req_e));
      if (req_e) chk({tag, "_addr"}, 64'(imem_addr), 64'(a_e));
      chk({tag, "_sel"}, 64'(sel), 64'(s_e));
   endtask

   task automatic sb_push(input logic [31:2] a, input logic [31:0] w, input logic m16,
                          input logic start_b1);
      exp_t e;
      e.w = w;
      if (!m16 || !start_b1) begin
         e.b1 = 1'b0;
         e.pc = {a, 1'b0};
         sbq.push_back(e);
      end
      if (m16) begin
         e.b1 = 1'b1;
         e.pc = {a, 1'b1};
         sbq.push_back(e);
      end
   endtask

   always @(negedge sysclk) begin
      exp_t e;
      chk("sel_onehot", 64'($onehot(sel)), 64'd1);
      if (rst_n && sel == S_LOAD) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_load actual=%h required=no_load", inst);
         end else begin
            e = sbq.pop_front();
            chk("load_inst", 64'(inst), 64'(e.w));
            chk("load_b1", 64'(b1), 64'(e.b1));
            chk("load_pc", 64'(if_pc), 64'(e.pc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w32 [4];
      w32[0] = 32'hA000_0001; w32[1] = 32'hA000_0002;
      w32[2] = 32'hA000_0003; w32[3] = 32'hA000_0004;

      // Reset state
      repeat (2) @(posedge sysclk);
      #1;
      at_neg();
      chk("rst_req", 64'(imem_req), 64'd0);
      chk("rst_addr", 64'(imem_addr), 64'h17F0_0000);
      chk("rst_sel", 64'(sel), 64'(S_ZERO));
      chk("rst_inst", 64'(inst), 64'(M32_NOP));
      chk("rst_b1", 64'(b1), 64'd0);
      chk("rst_pc", 64'(if_pc), 64'(RST_HA));
      chk("rst_mode", 64'(mode_n), 64'd0);
      next();
      rst_n = 1'b1;
      at_neg();
      chk("rel_req", 64'(imem_req), 64'd0);
      next();

      // M32, ACK every cycle
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1;
         imem_rdata = w32[i];
         at_neg();
         expect_bus("m32", 1'b1, 30'h17F0_0000 + 30'(i), (i == 0) ? S_ZERO : S_LOAD);
         sb_push(30'h17F0_0000 + 30'(i), w32[i], 1'b0, 1'b0);
         next();
      end
      imem_ack = 1'b0;
      at_neg();
      expect_bus("m32_tail", 1'b1, 30'h17F0_0004, S_LOAD);
      next();

      // ACK withheld: one stable outstanding request, nothing to load
      for (int i = 0; i < 6; i++) begin
         at_neg();
         expect_bus("stall", 1'b1, 30'h17F0_0004, S_ZERO);
         next();
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hB000_0004;
      at_neg();
      expect_bus("stall_ack", 1'b1, 30'h17F0_0004, S_ZERO);
      sb_push(30'h17F0_0004, 32'hB000_0004, 1'b0, 1'b0);
      next();

      // HOLD for 5 cycles while fetch fills the FIFO
      rhold = 1'b1;
      imem_rdata = 32'hB000_0005;
      at_neg();
      expect_bus("hold0", 1'b1, 30'h17F0_0005, S_HOLD);
      sb_push(30'h17F0_0005, 32'hB000_0005, 1'b0, 1'b0);
      next();
      imem_ack = 1'b0;
      for (int i = 1; i < 5; i++) begin
         at_neg();
         expect_bus("hold_full", 1'b0, 30'h0, S_HOLD);
         chk("hold_inst", 64'(inst), 64'hB000_0004);
         chk("hold_pc", 64'(if_pc), 64'({30'h17F0_0004, 1'b0}));
         next();
      end
      rhold = 1'b0;
      at_neg();
      expect_bus("release0", 1'b0, 30'h0, S_LOAD);
      next();
      at_neg();
      expect_bus("release1", 1'b1, 30'h17F0_0006, S_LOAD);
      next();

      // Redirect to byte 0x102 in M16 while the request to 0x17F0_0006 is outstanding
      redirect = 1'b1;
      redirect_addr = 31'h81;
      redirect_mode = 1'b1;
      at_neg();
      expect_bus("redir", 1'b1, 30'h17F0_0006, S_ZERO);
      next();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         at_neg();
         expect_bus("redir_wait", 1'b1, 30'h17F0_0006, S_ZERO);
         next();
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      at_neg();
      expect_bus("stale_ack", 1'b1, 30'h17F0_0006, S_ZERO);
      next();
      imem_rdata = 32'hAAAA_5555;
      at_neg();
      expect_bus("tgt0", 1'b1, 30'h40, S_ZERO);
      chk("tgt_mode", 64'(mode_n), 64'd1);
      sb_push(30'h40, 32'hAAAA_5555, 1'b1, 1'b1);
      next();

      // M16 halfword stepping
      imem_rdata = 32'h1111_2222;
      at_neg();
      expect_bus("m16_a", 1'b1, 30'h41, S_LOAD);
      sb_push(30'h41, 32'h1111_2222, 1'b1, 1'b0);
      next();
      imem_rdata = 32'h3333_4444;
      at_neg();
      expect_bus("m16_b", 1'b1, 30'h42, S_LOAD);
      sb_push(30'h42, 32'h3333_4444, 1'b1, 1'b0);
      next();
      imem_ack = 1'b0;
      at_neg();
      expect_bus("m16_full", 1'b0, 30'h0, S_LOAD);
      next();
      at_neg();
      expect_bus("m16_c", 1'b1, 30'h43, S_LOAD);
      next();
      at_neg();
      expect_bus("m16_d", 1'b1, 30'h43, S_LOAD);
      next();
      at_neg();
      expect_bus("m16_empty", 1'b1, 30'h43, S_ZERO);

      // Asynchronous reset in the middle of the outstanding request
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 64'(imem_req), 64'd0);
      chk("arst_sel", 64'(sel), 64'(S_ZERO));
      chk("arst_addr", 64'(imem_addr), 64'h17F0_0000);
      next();
      next();
      rst_n = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      at_neg();
      expect_bus("late_ack", 1'b0, 30'h0, S_ZERO);
      next();
      imem_rdata = 32'h0C0C_0C0C;
      at_neg();
      expect_bus("restart", 1'b1, 30'h17F0_0000, S_ZERO);
      chk("restart_mode", 64'(mode_n), 64'd0);
      sb_push(30'h17F0_0000, 32'h0C0C_0C0C, 1'b0, 1'b0);
      next();
      imem_rdata = 32'h0D0D_0D0D;
      at_neg();
      expect_bus("restart1", 1'b1, 30'h17F0_0001, S_LOAD);
      next();

      // Redirect with nothing outstanding, M32 target with bit 1 set (byte 0x206)
      imem_ack = 1'b0;
      redirect = 1'b1;
      redirect_addr = 31'h103;
      redirect_mode = 1'b0;
      at_neg();
      expect_bus("redir2", 1'b0, 30'h0, S_ZERO);
      next();
      redirect = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'h0E0E_0E0E;
      at_neg();
      expect_bus("redir2_req", 1'b1, 30'h81, S_ZERO);
      chk("redir2_pc", 64'(if_pc), 64'h102);
      chk("redir2_b1", 64'(b1), 64'd0);
      sb_push(30'h81, 32'h0E0E_0E0E, 1'b0, 1'b0);
      next();
      imem_ack = 1'b0;
      at_neg();
      chk("redir2_load", 64'(sel), 64'(S_LOAD));
      next();
      at_neg();

      chk("sb_drain", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
